noc_port_arbiter: RTL and testbench

NOC_PORT_ARBITER -- requirements
Module: noc_port_arbiter

---
 rtl/noc_pkg.sv | 15 +
 rtl/rr_picker.sv | 20 ++
 rtl/noc_port_arbiter.sv | 120 ++++++++++++
 tb/tb_noc_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: flit type codes and arbiter FSM state encodings shared across the NoC port logic.
package noc_pkg;
    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2
    } state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first requester at or after rr_ptr.
module rr_picker
    import noc_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int PTR_W     = 3
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [NUM_PORTS-1:0] pick
);
    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        pick = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (((req >> ((int'(rr_ptr) + i) % NUM_PORTS)) & NUM_PORTS'(1)) != '0)
                pick = NUM_PORTS'(1) << ((int'(rr_ptr) + i) % NUM_PORTS);
        end
    end
endmodule

// File: rtl/noc_port_arbiter.sv
// noc_port_arbiter: wormhole round-robin arbiter moving flits from NUM_PORTS FIFOs onto one link.
// Define ARB_STATS_EN to add per-port saturating completed-packet counters (pkt_cnt).
module noc_port_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*FLIT_W-1:0] flit_in,
    output logic [NUM_PORTS-1:0]        rd_en,
    input  logic                        out_ready,
    output logic [FLIT_W-1:0]           out_flit,
    output logic                        out_valid,
    output logic [NUM_PORTS-1:0]        grant,
    output logic                        err
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]     pkt_cnt
`endif
);
    localparam int PTR_W = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;

    state_t                state, state_nx;
    logic [NUM_PORTS-1:0]  grant_nx, pick;
    logic [PTR_W-1:0]      rr_ptr, ptr_nx, gidx;
    logic                  in_pkt, in_pkt_nx, err_nx, last, bad;
    logic [FLIT_W-1:0]     sel;
    flit_t                 ftype;

    rr_picker #(.NUM_PORTS(NUM_PORTS), .PTR_W(PTR_W)) u_pick (
        .req   (req),
        .rr_ptr(rr_ptr),
        .pick  (pick)
    );

    always_comb begin
        sel  = '0;
        gidx = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
                sel  = flit_in[p*FLIT_W +: FLIT_W];
                gidx = PTR_W'(p);
            end
        end
    end

    assign ftype = flit_t'(sel[FLIT_W-1 -: 2]);
    assign last  = ftype == FLIT_TAIL || ftype == FLIT_SINGLE;
    // A packet must open with head/single, and a head may not appear inside one.
    assign bad   = in_pkt ? ftype == FLIT_HEAD : !(ftype == FLIT_HEAD || ftype == FLIT_SINGLE);

    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        ptr_nx    = rr_ptr;
        in_pkt_nx = in_pkt;
        err_nx    = err;
        rd_en     = '0;
        out_valid = 1'b0;
        out_flit  = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_nx = pick;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (|(req & grant) && out_ready) begin
                    rd_en    = grant;
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                out_valid = 1'b1;
                out_flit  = sel;
                err_nx    = err | bad;
                in_pkt_nx = !last;
                state_nx  = last ? IDLE : ISSUE;
                if (last) begin
                    grant_nx = '0;
                    ptr_nx   = gidx == PTR_W'(NUM_PORTS - 1) ? '0 : gidx + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            in_pkt <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            grant  <= grant_nx;
            rr_ptr <= ptr_nx;
            in_pkt <= in_pkt_nx;
            err    <= err_nx;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else if (state == CHECK && last) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant[p] && pkt_cnt[p*16 +: 16] != 16'hFFFF)
                    pkt_cnt[p*16 +: 16] <= pkt_cnt[p*16 +: 16] + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_noc_port_arbiter.sv
// tb_noc_port_arbiter: directed and randomized checks of noc_port_arbiter against a packet-level round-robin model.
module tb_noc_port_arbiter;
    localparam int NP = 5;
    localparam int FW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NP-1:0] req = '0;
    logic [NP*FW-1:0] flit_in = '0;
    logic out_ready = 1'b1;
    logic [NP-1:0] rd_en, grant;
    logic [FW-1:0] out_flit;
    logic out_valid, err;
`ifdef ARB_STATS_EN
    logic [NP*16-1:0] pkt_cnt;
`endif

    int total = 0;
    int bad = 0;
    logic [FW-1:0] fq [NP][$];
    logic [NP-1:0] pop;

    always #5 clk = ~clk;

    noc_port_arbiter #(.NUM_PORTS(NP), .FLIT_W(FW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .flit_in  (flit_in),
        .rd_en    (rd_en),
        .out_ready(out_ready),
        .out_flit (out_flit),
        .out_valid(out_valid),
        .grant    (grant),
        .err      (err)
`ifdef ARB_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt)
`endif
    );

    // FIFO model with registered read data: a pop seen at the edge shows its word just after it.
    always @(posedge clk) begin
        pop = rd_en;
        #1;
        if (!rst_n) flit_in = '0;
        for (int p = 0; p < NP; p++) begin
            if (pop[p] && fq[p].size() > 0) flit_in[p*FW +: FW] = fq[p].pop_front();
            req[p] = fq[p].size() != 0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        for (int p = 0; p < NP; p++) fq[p].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_grant(output bit ok);
        ok = grant != '0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = grant != '0;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = grant == '0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = grant == '0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total += 5;
        if (grant !== '0) begin bad++; $display("FAIL reset_grant: got %b want 0", grant); end
        if (rd_en !== '0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_flit !== '0) begin bad++; $display("FAIL reset_out_flit: got %h want 0", out_flit); end
        if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_single_port();
        bit ok;
        logic [FW-1:0] exp_f [3] = '{32'h4000_00AA, 32'h0000_00BB, 32'h8000_00CC};
        do_reset();
        for (int i = 0; i < 3; i++) fq[0].push_back(exp_f[i]);
        wait_grant(ok);
        total++;
        if (!ok || grant !== 5'b00001 || rd_en !== 5'b00001) begin
            bad++; $display("FAIL single_first_grant: got grant=%b rd_en=%b want 00001/00001", grant, rd_en);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            total += 2;
            if (out_valid !== (k % 2 == 1)) begin
                bad++; $display("FAIL single_valid_c%0d: got %b want %b", k, out_valid, k % 2 == 1);
            end
            if (grant !== (k <= 5 ? 5'b00001 : 5'b00000)) begin
                bad++; $display("FAIL single_grant_c%0d: got %b want %b", k, grant, k <= 5 ? 5'b00001 : 5'b00000);
            end
            if (k % 2 == 1) begin
                total++;
                if (out_flit !== exp_f[k/2]) begin
                    bad++; $display("FAIL single_flit_c%0d: got %h want %h", k, out_flit, exp_f[k/2]);
                end
            end
        end
    endtask

    task automatic test_rr();
        bit ok;
        do_reset();
        fq[1].push_back(32'h4000_0011); fq[1].push_back(32'h8000_0011);
        fq[4].push_back(32'h4000_0044); fq[4].push_back(32'h8000_0044);
        wait_grant(ok);
        total++;
        if (!ok || grant !== 5'b00010) begin bad++; $display("FAIL rr_first: got %b want 00010", grant); end
        wait_idle(ok);
        wait_grant(ok);
        total++;
        if (!ok || grant !== 5'b10000) begin bad++; $display("FAIL rr_second: got %b want 10000", grant); end
        wait_idle(ok);
        fq[0].push_back(32'hC000_0000);
        fq[3].push_back(32'hC000_0003);
        wait_grant(ok);
        total++;
        if (!ok || grant !== 5'b00001) begin bad++; $display("FAIL rr_wrap: got %b want 00001", grant); end
        wait_idle(ok);
        wait_grant(ok);
        total++;
        if (!ok || grant !== 5'b01000) begin bad++; $display("FAIL rr_after_wrap: got %b want 01000", grant); end
        wait_idle(ok);
    endtask

    task automatic test_lock();
        bit ok, seen;
        do_reset();
        fq[0].push_back(32'h4000_0A00);
        wait_grant(ok);
        fq[3].push_back(32'hC000_0033);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if (grant !== 5'b00001 || (k > 1 && rd_en !== '0)) begin
                bad++; $display("FAIL lock_stall_c%0d: got grant=%b rd_en=%b want 00001/00000", k, grant, rd_en);
            end
        end
        fq[0].push_back(32'h0000_0A01);
        fq[0].push_back(32'h8000_0A02);
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            total++;
            if (grant !== 5'b00001) begin bad++; $display("FAIL lock_hold_c%0d: got %b want 00001", k, grant); end
            seen = out_valid && out_flit == 32'h8000_0A02;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL lock_tail: got no tail want %h", 32'h8000_0A02); end
        wait_idle(ok);
        wait_grant(ok);
        total++;
        if (!ok || grant !== 5'b01000) begin bad++; $display("FAIL lock_next: got %b want 01000", grant); end
        wait_idle(ok);
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        out_ready = 1'b0;
        fq[2].push_back(32'h4000_0222);
        fq[2].push_back(32'h8000_0222);
        wait_grant(ok);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (rd_en !== '0 || out_valid !== 1'b0 || grant !== 5'b00100) begin
                bad++; $display("FAIL bp_hold_c%0d: got rd_en=%b valid=%b grant=%b want 00000/0/00100", k, rd_en, out_valid, grant);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (rd_en !== 5'b00100) begin bad++; $display("FAIL bp_resume: got %b want 00100", rd_en); end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_flit !== 32'h4000_0222) begin
            bad++; $display("FAIL bp_flit: got valid=%b flit=%h want 1/40000222", out_valid, out_flit);
        end
        wait_idle(ok);
    endtask

    task automatic test_err();
        bit ok;
        do_reset();
        fq[0].push_back(32'h0000_0001);
        fq[0].push_back(32'h8000_0002);
        wait_grant(ok);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_flit !== 32'h0000_0001) begin
            bad++; $display("FAIL err_forward: got valid=%b flit=%h want 1/00000001", out_valid, out_flit);
        end
        @(negedge clk);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err); end
        wait_idle(ok);
        repeat (3) @(negedge clk);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
        fq[0].push_back(32'h4000_0005);
        fq[0].push_back(32'h0000_0006);
        wait_grant(ok);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (grant !== '0 || rd_en !== '0 || out_valid !== 1'b0 || out_flit !== '0 || err !== 1'b0) begin
            bad++; $display("FAIL async_reset: got grant=%b rd_en=%b valid=%b flit=%h err=%b want all 0", grant, rd_en, out_valid, out_flit, err);
        end
        do_reset();
    endtask

    task automatic test_random();
        bit ok;
        int mptr, npk, len;
        int mlen [NP][$];
        logic [FW-1:0] mdat [NP][$];
        int exp_p [$];
        logic [FW-1:0] exp_f [$];
        logic [FW-1:0] f;
        do_reset();
        mptr = 0;
        for (int r = 0; r < 6; r++) begin
            npk = 0;
            for (int p = 0; p < NP; p++) begin
                for (int n = $urandom_range(0, 2); n > 0; n--) begin
                    len = $urandom_range(1, 4);
                    mlen[p].push_back(len);
                    npk++;
                    for (int j = 0; j < len; j++) begin
                        f[FW-3:0] = 30'($urandom);
                        f[FW-1:FW-2] = len == 1 ? 2'b11 : j == 0 ? 2'b01 : j == len - 1 ? 2'b10 : 2'b00;
                        mdat[p].push_back(f);
                        fq[p].push_back(f);
                    end
                end
            end
            // Whole packets leave in round-robin order of the ports holding them.
            while (npk > 0) begin
                for (int i = 0; i < NP; i++) begin
                    int p = (mptr + i) % NP;
                    if (mlen[p].size() > 0) begin
                        len = mlen[p].pop_front();
                        repeat (len) begin
                            exp_p.push_back(p);
                            exp_f.push_back(mdat[p].pop_front());
                        end
                        mptr = (p + 1) % NP;
                        npk--;
                        break;
                    end
                end
            end
            for (int c = 0; c < 600 && exp_f.size() > 0; c++) begin
                @(negedge clk);
                total++;
                if (!$onehot0(rd_en)) begin bad++; $display("FAIL rand_rd_onehot: got %b want one-hot-or-zero", rd_en); end
                if (out_valid) begin
                    total++;
                    if (grant !== NP'(1) << exp_p[0] || out_flit !== exp_f[0]) begin
                        bad++; $display("FAIL rand_flit: got port=%b flit=%h want port=%b flit=%h", grant, out_flit, NP'(1) << exp_p[0], exp_f[0]);
                    end
                    void'(exp_p.pop_front());
                    void'(exp_f.pop_front());
                end
                out_ready = $urandom_range(0, 3) != 0;
            end
            total++;
            if (exp_f.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d flits left want 0", exp_f.size()); end
            exp_f.delete();
            exp_p.delete();
            out_ready = 1'b1;
            wait_idle(ok);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || grant !== '0) begin
                bad++; $display("FAIL rand_idle: got valid=%b grant=%b want 0/00000", out_valid, grant);
            end
        end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL rand_err: got %b want 0", err); end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 3; i++) fq[2].push_back(32'hC000_0000);
        repeat (20) @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            total++;
            if (pkt_cnt[p*16 +: 16] !== (p == 2 ? 16'd3 : 16'd0)) begin
                bad++; $display("FAIL stats_p%0d: got %0d want %0d", p, pkt_cnt[p*16 +: 16], p == 2 ? 3 : 0);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_port();
        test_rr();
        test_lock();
        test_backpressure();
        test_err();
        test_random();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
